// File: rtl/sram_parity_error_log_if.sv
// Bus bundle between the parity-error log and its driver: read/parity alignment
// inputs, software controls, and the log/status outputs.
interface sram_parity_error_log_if #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              read_enable;
  logic [ADDR_W-1:0] raddr;
  logic              parity_error;
  logic              irq_enable;
  logic              clear;
  logic              log_pop;
  logic              log_valid;
  logic [ADDR_W-1:0] log_addr;
  logic [LVL_W-1:0]  log_level;
  logic [CNT_W-1:0]  err_count;
  logic              overflow;
  logic              irq;

  modport master (
    output read_enable, raddr, parity_error, irq_enable, clear, log_pop,
    input  log_valid, log_addr, log_level, err_count, overflow, irq
  );

  modport slave (
    input  read_enable, raddr, parity_error, irq_enable, clear, log_pop,
    output log_valid, log_addr, log_level, err_count, overflow, irq
  );
endinterface

// File: rtl/sram_parity_error_log.sv
// Aligns each read address with the registered parity flag, logs failing
// addresses in a FWFT FIFO, counts errors and raises a level interrupt.
module sram_parity_error_log #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic                    clk,
  input logic                    reset,
  sram_parity_error_log_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic              rd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  head, tail, head_nxt, tail_nxt;
  logic [LVL_W-1:0]  level, level_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              ovf, ovf_nxt, irq_q, irq_nxt;
  logic              err_evt, empty, full, pop_ok, push_ok;

  assign err_evt = bus.parity_error & rd_d;
  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign pop_ok  = bus.log_pop & ~empty;
  // A pop in the same cycle frees a slot, so a full log still accepts the push.
  assign push_ok = err_evt & (~full | pop_ok);

  // The alignment stage ignores clear so a read issued during clear is still logged.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d   <= 1'b0;
      addr_d <= '0;
    end else begin
      rd_d <= bus.read_enable;
      if (bus.read_enable) begin
        addr_d <= bus.raddr;
      end
    end
  end

  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    level_nxt = level;
    count_nxt = count;
    ovf_nxt   = ovf;
    if (bus.clear) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      level_nxt = '0;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else begin
      if (push_ok) tail_nxt = tail + 1'b1;
      if (pop_ok)  head_nxt = head + 1'b1;
      if (push_ok & ~pop_ok) begin
        level_nxt = level + 1'b1;
      end else if (pop_ok & ~push_ok) begin
        level_nxt = level - 1'b1;
      end
      if (err_evt && (count != '1)) count_nxt = count + 1'b1;
      if (err_evt & ~push_ok) ovf_nxt = 1'b1;
    end
    irq_nxt = bus.irq_enable & ((level_nxt != '0) | ovf_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
      count <= '0;
      ovf   <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      head  <= head_nxt;
      tail  <= tail_nxt;
      level <= level_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
      irq_q <= irq_nxt;
    end
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok & ~bus.clear & ~reset) begin
      mem[tail] <= addr_d;
    end
  end

  assign bus.log_valid = ~empty;
  assign bus.log_addr  = empty ? '0 : mem[head];
  assign bus.log_level = level;
  assign bus.err_count = count;
  assign bus.overflow  = ovf;
  assign bus.irq       = irq_q;
endmodule

// File: tb/tb_sram_parity_error_log.sv
// Scoreboard bench: two logs (16-bit and 3-bit counters) share one random and
// directed stimulus stream and are checked against a queue-based model.
module tb_sram_parity_error_log;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
  localparam int CNT_W_SAT  = 3;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  logic read_enable, parity_error, irq_enable, clear, log_pop;
  logic [ADDR_W-1:0] raddr;

  always #5 clk = ~clk;

  sram_parity_error_log_if #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W))     bus_a ();
  sram_parity_error_log_if #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W_SAT)) bus_b ();

  assign bus_a.read_enable  = read_enable;
  assign bus_a.raddr        = raddr;
  assign bus_a.parity_error = parity_error;
  assign bus_a.irq_enable   = irq_enable;
  assign bus_a.clear        = clear;
  assign bus_a.log_pop      = log_pop;
  assign bus_b.read_enable  = read_enable;
  assign bus_b.raddr        = raddr;
  assign bus_b.parity_error = parity_error;
  assign bus_b.irq_enable   = irq_enable;
  assign bus_b.clear        = clear;
  assign bus_b.log_pop      = log_pop;

  sram_parity_error_log #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  sram_parity_error_log #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W_SAT)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  bit               m_rd_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic [ADDR_W-1:0] model_log[$];
  logic [ADDR_W-1:0] exp_q_a[$];
  logic [ADDR_W-1:0] exp_q_b[$];
  int               m_cnt;
  bit               m_ovf, m_irq;

  // Reference model: the log is a plain queue; everything follows from its size.
  task automatic modelStep();
    bit evt, popped;
    evt = parity_error && m_rd_d;
    if (reset) begin
      model_log.delete(); exp_q_a.delete(); exp_q_b.delete();
      m_cnt = 0; m_ovf = 0; m_irq = 0; m_rd_d = 0; m_addr_d = '0;
    end else begin
      if (clear) begin
        model_log.delete(); exp_q_a.delete(); exp_q_b.delete();
        m_cnt = 0; m_ovf = 0;
      end else begin
        popped = log_pop && (model_log.size() > 0);
        if (evt) begin
          m_cnt++;
          if (model_log.size() < FIFO_DEPTH || popped) begin
            model_log.push_back(m_addr_d);
            exp_q_a.push_back(m_addr_d);
            exp_q_b.push_back(m_addr_d);
          end else begin
            m_ovf = 1;
          end
        end
        if (popped) void'(model_log.pop_front());
      end
      m_irq = irq_enable && ((model_log.size() > 0) || m_ovf);
      m_rd_d = read_enable;
      if (read_enable) m_addr_d = raddr;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit re, input logic [ADDR_W-1:0] ra,
                               input bit pe, input bit pop, input bit clr, input bit ien);
    @(negedge clk);
    reset = rst; read_enable = re; raddr = ra; parity_error = pe;
    log_pop = pop; clear = clr; irq_enable = ien;
    @(posedge clk);
    modelStep();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkDut(input string tag, input logic v, input logic [ADDR_W-1:0] a,
                          input logic [LVL_W-1:0] lvl, input logic [31:0] cnt,
                          input logic ovf, input logic irq, input int cnt_max);
    int exp_cnt;
    exp_cnt = (m_cnt > cnt_max) ? cnt_max : m_cnt;
    checkOutput({tag, "_valid"}, 32'(v), 32'(model_log.size() > 0));
    checkOutput({tag, "_level"}, 32'(lvl), 32'(model_log.size()));
    checkOutput({tag, "_err_count"}, cnt, 32'(exp_cnt));
    checkOutput({tag, "_overflow"}, 32'(ovf), 32'(m_ovf));
    checkOutput({tag, "_irq"}, 32'(irq), 32'(m_irq));
    if (model_log.size() == 0) checkOutput({tag, "_addr_empty"}, 32'(a), 32'h0);
  endtask

  // Monitor: checks status every cycle and pops the scoreboard on each accepted pop.
  initial begin
    logic [ADDR_W-1:0] e;
    forever begin
      @(negedge clk); #1;
      if (checking) begin
        checkDut("a", bus_a.log_valid, bus_a.log_addr, bus_a.log_level, 32'(bus_a.err_count),
                 bus_a.overflow, bus_a.irq, (1 << CNT_W) - 1);
        checkDut("b", bus_b.log_valid, bus_b.log_addr, bus_b.log_level, 32'(bus_b.err_count),
                 bus_b.overflow, bus_b.irq, (1 << CNT_W_SAT) - 1);
        if (log_pop && !reset && !clear && bus_a.log_valid) begin
          if (exp_q_a.size() == 0) checkOutput("pop_a_unexpected", 32'(bus_a.log_addr), 32'hFFFF_FFFF);
          else begin
            e = exp_q_a.pop_front();
            checkOutput("pop_addr_a", 32'(bus_a.log_addr), 32'(e));
          end
        end
        if (log_pop && !reset && !clear && bus_b.log_valid) begin
          if (exp_q_b.size() == 0) checkOutput("pop_b_unexpected", 32'(bus_b.log_addr), 32'hFFFF_FFFF);
          else begin
            e = exp_q_b.pop_front();
            checkOutput("pop_addr_b", 32'(bus_b.log_addr), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    reset = 1; read_enable = 0; raddr = '0; parity_error = 0;
    log_pop = 0; clear = 0; irq_enable = 1;
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checking = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 1);

    // Single error, then drain.
    applyStimulus(0, 1, 8'h3C, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Spurious flag with no preceding read, and pop while empty.
    applyStimulus(0, 0, 0, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Fill and overflow, drain, then clear.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'(8'h10 + i), i > 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Full log with a push and pop in the same cycle.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(8'h30 + i), i > 0, 0, 0, 1);
    applyStimulus(0, 1, 8'h20, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Clear colliding with an error event while a new read starts.
    applyStimulus(0, 1, 8'h40, 0, 0, 0, 1);
    applyStimulus(0, 1, 8'h41, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);

    // Saturate the narrow counter with continuous pops, then reset mid-stream.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, i < 9, 8'(8'h50 + i), i > 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'(8'h60 + i), 1, 0, 0, 1);
    applyStimulus(1, 1, 8'h70, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(499, 0) == 0,
                    $urandom_range(9, 0) < 7,
                    8'($urandom()),
                    $urandom_range(1, 0) == 1,
                    $urandom_range(9, 0) < 4,
                    $urandom_range(99, 0) == 0,
                    $urandom_range(9, 0) != 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    @(negedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_parity_error_log.md
Name: sram_parity_error_log

Overview:
Downstream consumer of the SRAM controller's parity checker. It aligns each read address with the checker's registered parity_error flag and logs the failing addresses in a small first-word-fall-through FIFO. It also keeps a saturating error count and a sticky overflow flag, and raises a level interrupt for the system/CSR layer. Software drains the log through a pop handshake and resets it with clear.

Parameters:
ADDR_W, 8, width of the SRAM word address logged per error
FIFO_DEPTH, 4, number of error-address entries; power of two, at least 2
CNT_W, 16, width of the saturating total-error counter

Ports:
clk  in  1  system clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
read_enable  in  1  read strobe, same cycle as presented to the parity checker
raddr  in  ADDR_W  read address, same cycle as read_enable
parity_error  in  1  checker flag, registered; valid one cycle after read_enable
irq_enable  in  1  interrupt mask; 1 = enabled
clear  in  1  single-cycle pulse: flush log, zero counter, clear overflow
log_pop  in  1  consume head entry
log_valid  out  1  FIFO non-empty
log_addr  out  ADDR_W  head entry address, FWFT; 0 when empty
log_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
err_count  out  CNT_W  total detected errors, saturating
overflow  out  1  sticky; an error was dropped because the FIFO was full
irq  out  1  registered interrupt

Behaviour:
- Reset (synchronous, reset=1 at clk edge):
  - Pointers, occupancy, err_count, overflow, irq and the alignment stage go to 0.
  - log_valid=0, log_addr=0, log_level=0.
  - FIFO storage contents are don't-care.
- Alignment stage:
  - Each cycle: rd_d <= read_enable; when read_enable=1, addr_d <= raddr.
  - err_evt = parity_error & rd_d, combinational.
  - A parity_error with rd_d=0 is ignored.
- Push: on err_evt, write addr_d to the tail and increment occupancy, unless full.
  - If full with no accepted pop in the same cycle: entry dropped, overflow <= 1.
- Pop: log_pop & log_valid advances the head and decrements occupancy.
  - log_pop while empty is ignored and has no side effects.
- Simultaneous push and pop:
  - Occupancy unchanged; both accepted, even when full (no overflow).
  - When empty: the pop is ignored and the push is accepted.
- Pointers wrap modulo FIFO_DEPTH.
- log_addr reflects the head combinationally from storage, and is 0 when empty.
- err_count increments on every err_evt, including dropped ones; it holds at all-ones (2^CNT_W-1) once saturated.
- clear has priority over everything except reset. In a clear cycle:
  - Pointers, occupancy, err_count and overflow go to 0.
  - An err_evt or pop in the same cycle is discarded.
  - The alignment stage still updates, so a read started in the clear cycle is logged normally one cycle later.
- irq <= irq_enable & (log_valid_next | overflow_next), i.e. registered from post-update state.
  - irq asserts the cycle after the first logged error, and deasserts the cycle after the log is drained (if overflow=0) or after clear.
- Latency: read_enable at cycle N, parity_error at N+1, entry visible on log_valid/log_addr at N+2, irq at N+2.
- Back-to-back reads every cycle with errors every cycle are fully supported, one push per cycle.

Test Plan:
- Single error: reset, irq_enable=1, read raddr=0x3C at cycle N, parity_error=1 at N+1 -> at N+2: log_valid=1, log_addr=0x3C, log_level=1, err_count=1, irq=1; pop -> log_valid=0, irq=0 next cycle.
- Spurious flag: parity_error=1 with no read one cycle earlier -> err_count stays 0, log_valid stays 0.
- Fill and overflow: 5 consecutive erroring reads at 0x10..0x14 -> log_level=4, pops return 0x10,0x11,0x12,0x13 in order, overflow=1, err_count=5; irq stays 1 after draining until clear.
- Full with simultaneous push+pop: 4 entries, then pop in the same cycle as the 5th error (0x20) -> overflow=0, log_level=4, last entry popped = 0x20.
- Clear priority: clear pulse in the same cycle as err_evt -> err_count=0, log_level=0, overflow=0, irq=0; a read issued in the clear cycle with an error following is logged (err_count=1).
- Saturation with CNT_W=3: 9 erroring reads with continuous pops -> err_count holds at 7; reset mid-stream -> all outputs 0 the next cycle.
